// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver and make/break decoder driving a held direction vector
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       pclk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] key_o,
    output logic [7:0] scan_code_o,
    output logic       scan_strobe_o,
    output logic       frame_error_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_differ, filt_flip, fall;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [3:0]    arrow_q, arrow_d, wasd_q, wasd_d;
    logic [7:0]    code_q, code_d;
    logic          strobe_q, strobe_d, ferr_q, ferr_d;
    logic          accept;

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    assign filt_differ = (clk_s2_q != filt_q);
    assign filt_flip   = filt_differ && (filt_cnt_q == FILT_LAST);
    assign fall        = filt_flip && filt_q;

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (!filt_differ) begin
            filt_cnt_q <= '0;
        end else if (filt_flip) begin
            filt_q     <= ~filt_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            arrow_q  <= '0;
            wasd_q   <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            arrow_q  <= arrow_d;
            wasd_q   <= wasd_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
        ext_d    = ext_q;
        brk_d    = brk_q;
        arrow_d  = arrow_q;
        wasd_d   = wasd_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        accept   = 1'b0;

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_s2_q && (^{shift_q, par_q})) accept = 1'b1;
                    else                                  ferr_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end

        if (ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        if (accept) begin
            strobe_d = 1'b1;
            code_d   = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                // Hold bit index order matches key_o: [3]=right [2]=left [1]=down [0]=up.
                if (ext_q) begin
                    case (shift_q)
                        8'h75:   arrow_d[0] = ~brk_q;
                        8'h72:   arrow_d[1] = ~brk_q;
                        8'h6B:   arrow_d[2] = ~brk_q;
                        8'h74:   arrow_d[3] = ~brk_q;
                        default: ;
                    endcase
                end else begin
                    case (shift_q)
                        8'h1D:   wasd_d[0] = ~brk_q;
                        8'h1B:   wasd_d[1] = ~brk_q;
                        8'h1C:   wasd_d[2] = ~brk_q;
                        8'h23:   wasd_d[3] = ~brk_q;
                        default: ;
                    endcase
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign key_o         = arrow_q | wasd_q;
    assign scan_code_o   = code_q;
    assign scan_strobe_o = strobe_q;
    assign frame_error_o = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic [7:0] scan_code;
    logic       scan_strobe;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;
    int ferr_cyc = 0;
    int last_fall_cyc = 0;
    logic [7:0] exp_q[$];

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(1000)) dut (
        .pclk_i        (pclk),
        .rst_ni        (rst_n),
        .ps2_clk_i     (ps2_clk),
        .ps2_data_i    (ps2_data),
        .key_o         (key),
        .scan_code_o   (scan_code),
        .scan_strobe_o (scan_strobe),
        .frame_error_o (frame_error)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted byte must match the oldest pending expectation.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (scan_strobe || frame_error)
                check("strobe_error_exclusive", {31'b0, scan_strobe & frame_error}, 32'd0);
            if (frame_error) begin
                ferr_cnt++;
                ferr_cyc = cyc;
            end
            if (scan_strobe) begin
                strobe_cnt++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_strobe: observed %0h expected none", scan_code);
                end
                if (exp_q.size() != 0) check("scan_code", {24'b0, scan_code}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(25);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(50);
        ps2_clk = 1'b1;
        wait_cyc(25);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nfalls);
        logic [10:0] bits;
        bits = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        if (nfalls == 11 && !bad_par) exp_q.push_back(b);
        for (int i = 0; i < nfalls; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        wait_cyc(40);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    initial begin
        int s0, f0, d;

        wait_cyc(5);
        check("reset_key", {28'b0, key}, 32'd0);
        check("reset_scan_code", {24'b0, scan_code}, 32'd0);
        check("reset_strobe", {31'b0, scan_strobe}, 32'd0);
        check("reset_frame_error", {31'b0, frame_error}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        s0 = strobe_cnt;
        send(8'hE0); send(8'h75);
        check("ext_make_key", {28'b0, key}, 32'h1);
        check("ext_make_code", {24'b0, scan_code}, 32'h75);
        check("ext_make_strobes", strobe_cnt - s0, 32'd2);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break_key", {28'b0, key}, 32'h0);
        check("ext_break_strobes", strobe_cnt - s0, 32'd5);

        send(8'h1D);
        check("w_make", {28'b0, key}, 32'h1);
        send(8'hE0); send(8'h75);
        check("w_and_up", {28'b0, key}, 32'h1);
        send(8'hF0); send(8'h1D);
        check("w_break_up_held", {28'b0, key}, 32'h1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("both_released", {28'b0, key}, 32'h0);
        send(8'h23); send(8'hE0); send(8'h6B);
        check("right_left", {28'b0, key}, 32'hC);
        send(8'hF0); send(8'h23); send(8'hE0); send(8'hF0); send(8'h6B);
        check("right_left_released", {28'b0, key}, 32'h0);

        s0 = strobe_cnt; f0 = ferr_cnt;
        send_frame(8'h1D, 1'b1, 11);
        check("parity_error_pulse", ferr_cnt - f0, 32'd1);
        check("parity_no_strobe", strobe_cnt - s0, 32'd0);
        check("parity_key", {28'b0, key}, 32'h0);
        send(8'h1C);
        check("after_parity_key", {28'b0, key}, 32'h4);

        send(8'hE0);
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 5);
        for (int i = 0; i < 1200 && ferr_cnt == f0; i++) wait_cyc(1);
        check("timeout_pulse", ferr_cnt - f0, 32'd1);
        d = ferr_cyc - last_fall_cyc;
        check("timeout_delay_window", {31'b0, (d >= 1000 && d <= 1015)}, 32'd1);
        send(8'h72);
        check("timeout_ext_cleared_key", {28'b0, key}, 32'h4);
        check("timeout_next_code", {24'b0, scan_code}, 32'h72);

        send(8'hF0); send(8'h1C);
        check("left_released", {28'b0, key}, 32'h0);
        s0 = strobe_cnt; f0 = ferr_cnt;
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(5);
        ps2_data = 1'b1;
        wait_cyc(100);
        check("glitch_no_error", ferr_cnt - f0, 32'd0);
        check("glitch_no_strobe", strobe_cnt - s0, 32'd0);
        send(8'h1D);
        check("after_glitch_key", {28'b0, key}, 32'h1);

        send(8'h1B);
        check("pre_reset_key", {28'b0, key}, 32'h3);
        send_frame(8'h1D, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        check("midreset_key", {28'b0, key}, 32'h0);
        check("midreset_code", {24'b0, scan_code}, 32'h0);
        check("midreset_strobe", {31'b0, scan_strobe}, 32'd0);
        check("midreset_error", {31'b0, frame_error}, 32'd0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
        send(8'h1B);
        check("after_reset_key", {28'b0, key}, 32'h2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
